// File: rtl/vram_arbiter.sv
// Shares the single 8-bit VRAM port between video fetch (fixed priority) and the CPU bus,
// with a bounded CPU wait. Define VRAM_ARB_STATS_EN to add grant/starvation counters.
module vram_arbiter #(
  parameter int AW       = 24,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_vid_req,
  input  logic [AW-1:0] i_vid_addr,
  output logic          o_vid_ack,
  output logic          o_vid_valid,
  output logic [7:0]    o_vid_data,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [7:0]    i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic          o_cpu_valid,
  output logic [7:0]    o_cpu_rdata,
  output logic          o_vram_cs,
  output logic          o_vram_we,
  output logic [AW-1:0] o_vram_addr,
  output logic [7:0]    o_vram_wdata,
  input  logic [7:0]    i_vram_data
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic          i_stat_clr,
  output logic [15:0]   o_stat_vid_cnt,
  output logic [15:0]   o_stat_cpu_cnt,
  output logic [15:0]   o_stat_starve_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT} state_t;

  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);
  localparam logic [2:0] LAT_INIT = 3'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_lat_cnt;
  logic [7:0]    r_wait_cnt, w_wait_eff;
  logic          r_pend_vid, r_pend_cpu;
  logic          w_can_grant, w_gnt_vid, w_gnt_cpu, w_sample;
  logic          r_vram_cs, r_vram_we, r_vid_ack, r_cpu_ack, r_vid_valid, r_cpu_valid;
  logic [AW-1:0] r_vram_addr;
  logic [7:0]    r_vram_wdata, r_vid_data, r_cpu_rdata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A new grant can be issued from IDLE or straight out of a write access (back-to-back);
  // the requester sees ack and must present its next request (or drop req) in that cycle.
  assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_ACCESS) && r_vram_we);
  // wait_cnt clears one cycle after the CPU ack, so mask it in the ack cycle itself.
  assign w_wait_eff  = r_cpu_ack ? 8'd0 : r_wait_cnt;
  assign w_gnt_vid   = w_can_grant && i_vid_req && (!i_cpu_req || (w_wait_eff < MAX_W));
  assign w_gnt_cpu   = w_can_grant && !w_gnt_vid && i_cpu_req;
  assign w_sample    = (r_state == S_IDLE) && (r_pend_vid || r_pend_cpu);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_gnt_vid || w_gnt_cpu) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (!r_vram_we)                   w_state_nxt = (RD_LAT == 1) ? S_IDLE : S_RDWAIT;
        else if (w_gnt_vid || w_gnt_cpu) w_state_nxt = S_ACCESS;
        else                              w_state_nxt = S_IDLE;
      end
      S_RDWAIT: if (r_lat_cnt == 3'd0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lat_cnt    <= 3'd0;
      r_wait_cnt   <= 8'd0;
      r_pend_vid   <= 1'b0;
      r_pend_cpu   <= 1'b0;
      r_vram_cs    <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vid_ack    <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_cpu_valid  <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= 8'd0;
      r_vid_data   <= 8'd0;
      r_cpu_rdata  <= 8'd0;
    end else begin
      r_vram_cs <= w_gnt_vid || w_gnt_cpu;
      r_vram_we <= w_gnt_cpu && i_cpu_we;
      r_vid_ack <= w_gnt_vid;
      r_cpu_ack <= w_gnt_cpu;
      if (w_gnt_vid) begin
        r_vram_addr <= i_vid_addr;
      end else if (w_gnt_cpu) begin
        r_vram_addr <= i_cpu_addr;
        if (i_cpu_we) r_vram_wdata <= i_cpu_wdata;
      end

      if (r_state == S_ACCESS)                               r_lat_cnt <= LAT_INIT;
      else if ((r_state == S_RDWAIT) && (r_lat_cnt != 3'd0)) r_lat_cnt <= r_lat_cnt - 3'd1;

      if (r_cpu_ack || !i_cpu_req) r_wait_cnt <= 8'd0;
      else if (r_wait_cnt < MAX_W) r_wait_cnt <= r_wait_cnt + 8'd1;

      r_pend_vid <= w_gnt_vid ? 1'b1 : (w_sample ? 1'b0 : r_pend_vid);
      r_pend_cpu <= (w_gnt_cpu && !i_cpu_we) ? 1'b1 : (w_sample ? 1'b0 : r_pend_cpu);

      r_vid_valid <= w_sample && r_pend_vid;
      r_cpu_valid <= w_sample && r_pend_cpu;
      if (w_sample && r_pend_vid) r_vid_data  <= i_vram_data;
      if (w_sample && r_pend_cpu) r_cpu_rdata <= i_vram_data;
    end
  end

  assign o_vram_cs    = r_vram_cs;
  assign o_vram_we    = r_vram_we;
  assign o_vram_addr  = r_vram_addr;
  assign o_vram_wdata = r_vram_wdata;
  assign o_vid_ack    = r_vid_ack;
  assign o_cpu_ack    = r_cpu_ack;
  assign o_vid_valid  = r_vid_valid;
  assign o_cpu_valid  = r_cpu_valid;
  assign o_vid_data   = r_vid_data;
  assign o_cpu_rdata  = r_cpu_rdata;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stat_vid, r_stat_cpu, r_stat_starve;

  // Starvation counts only CPU grants that actually beat a waiting video request.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_stat_vid    <= 16'd0;
      r_stat_cpu    <= 16'd0;
      r_stat_starve <= 16'd0;
    end else if (i_stat_clr) begin
      r_stat_vid    <= 16'd0;
      r_stat_cpu    <= 16'd0;
      r_stat_starve <= 16'd0;
    end else begin
      if (w_gnt_vid) r_stat_vid <= r_stat_vid + 16'd1;
      if (w_gnt_cpu) r_stat_cpu <= r_stat_cpu + 16'd1;
      if (w_gnt_cpu && i_vid_req && (w_wait_eff == MAX_W)) r_stat_starve <= r_stat_starve + 16'd1;
    end
  end

  assign o_stat_vid_cnt    = r_stat_vid;
  assign o_stat_cpu_cnt    = r_stat_cpu;
  assign o_stat_starve_cnt = r_stat_starve;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table plus hand sequences for reset, starvation and stats.
module tb_vram_arbiter;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_vid_req;
  logic [23:0] i_vid_addr;
  logic        o_vid_ack, o_vid_valid;
  logic [7:0]  o_vid_data;
  logic        i_cpu_req, i_cpu_we;
  logic [23:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_ack, o_cpu_valid;
  logic [7:0]  o_cpu_rdata;
  logic        o_vram_cs, o_vram_we;
  logic [23:0] o_vram_addr;
  logic [7:0]  o_vram_wdata;
  logic [7:0]  i_vram_data;
`ifdef VRAM_ARB_STATS_EN
  logic        i_stat_clr;
  logic [15:0] o_stat_vid_cnt, o_stat_cpu_cnt, o_stat_starve_cnt;
`endif

  vram_arbiter #(.AW(24), .RD_LAT(2), .MAX_WAIT(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
    .o_vid_ack(o_vid_ack), .o_vid_valid(o_vid_valid), .o_vid_data(o_vid_data),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_valid(o_cpu_valid), .o_cpu_rdata(o_cpu_rdata),
    .o_vram_cs(o_vram_cs), .o_vram_we(o_vram_we), .o_vram_addr(o_vram_addr),
    .o_vram_wdata(o_vram_wdata), .i_vram_data(i_vram_data)
`ifdef VRAM_ARB_STATS_EN
    , .i_stat_clr(i_stat_clr), .o_stat_vid_cnt(o_stat_vid_cnt),
    .o_stat_cpu_cnt(o_stat_cpu_cnt), .o_stat_starve_cnt(o_stat_starve_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  vram;
    logic [5:0]  ctl;    // {cs, we, vid_ack, cpu_ack, vid_valid, cpu_valid}
    logic [23:0] addr;
    logic [7:0]  wdat;
    logic [7:0]  vdat;
    logic [7:0]  cdat;
  } vec_t;

  vec_t vec [15];
  int   n_pass  = 0;
  int   n_total = 0;
  int   g_cyc [16];
  logic g_cpu [16];
  int   ng, dual;
  logic seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [5:0] ctl_now();
    return {o_vram_cs, o_vram_we, o_vid_ack, o_cpu_ack, o_vid_valid, o_cpu_valid};
  endfunction

  function automatic logic [53:0] all_outs();
    return {o_vid_ack, o_vid_valid, o_vid_data, o_cpu_ack, o_cpu_valid, o_cpu_rdata,
            o_vram_cs, o_vram_we, o_vram_addr, o_vram_wdata};
  endfunction

  initial begin
    vec[0]  = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h00FFFF, 8'hA5, 8'h00, 6'b110100, 24'h00FFFF, 8'hA5, 8'h5A, 8'h00};
    vec[1]  = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h010000, 8'h3C, 8'h00, 6'b110100, 24'h010000, 8'h3C, 8'h5A, 8'h00};
    vec[2]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      8'h00, 8'h00, 6'b000000, 24'h010000, 8'h3C, 8'h5A, 8'h00};
    vec[3]  = '{1'b0, 24'h0,      1'b1, 1'b0, 24'h000777, 8'h00, 8'h00, 6'b100100, 24'h000777, 8'h3C, 8'h5A, 8'h00};
    vec[4]  = '{1'b1, 24'h0ABCDE, 1'b0, 1'b0, 24'h0,      8'h00, 8'h00, 6'b000000, 24'h000777, 8'h3C, 8'h5A, 8'h00};
    vec[5]  = '{1'b1, 24'h0ABCDE, 1'b0, 1'b0, 24'h0,      8'h00, 8'h00, 6'b000000, 24'h000777, 8'h3C, 8'h5A, 8'h00};
    vec[6]  = '{1'b1, 24'h0ABCDE, 1'b0, 1'b0, 24'h0,      8'h00, 8'hC3, 6'b101001, 24'h0ABCDE, 8'h3C, 8'h5A, 8'hC3};
    vec[7]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      8'h00, 8'h11, 6'b000000, 24'h0ABCDE, 8'h3C, 8'h5A, 8'hC3};
    vec[8]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      8'h00, 8'h22, 6'b000000, 24'h0ABCDE, 8'h3C, 8'h5A, 8'hC3};
    vec[9]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      8'h00, 8'h96, 6'b000010, 24'h0ABCDE, 8'h3C, 8'h96, 8'hC3};
    vec[10] = '{1'b1, 24'h000020, 1'b1, 1'b1, 24'h000010, 8'h5F, 8'h00, 6'b101000, 24'h000020, 8'h3C, 8'h96, 8'hC3};
    vec[11] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000010, 8'h5F, 8'h00, 6'b000000, 24'h000020, 8'h3C, 8'h96, 8'hC3};
    vec[12] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000010, 8'h5F, 8'h00, 6'b000000, 24'h000020, 8'h3C, 8'h96, 8'hC3};
    vec[13] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000010, 8'h5F, 8'h44, 6'b110110, 24'h000010, 8'h5F, 8'h44, 8'hC3};
    vec[14] = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      8'h00, 8'h00, 6'b000000, 24'h000010, 8'h5F, 8'h44, 8'hC3};

    i_reset_n = 1'b0; i_vid_req = 1'b1; i_vid_addr = 24'h000123;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 24'h0; i_cpu_wdata = 8'h0; i_vram_data = 8'h0;
`ifdef VRAM_ARB_STATS_EN
    i_stat_clr = 1'b0;
`endif

    // Reset with video requesting, then the first video read of 0x000123.
    tick(); tick();
    check("rst_outs", 64'(all_outs()), 64'd0);
    i_reset_n = 1'b1;
    tick(); check("rst_sync1_cs", 64'(ctl_now()), 64'd0);
    tick(); check("rst_sync2_cs", 64'(ctl_now()), 64'd0);
    tick(); check("first_grant", 64'(ctl_now()), 64'(6'b101000));
    check("first_addr", 64'(o_vram_addr), 64'h000123);
    i_vid_req = 1'b0; i_vid_addr = 24'h0;
    tick(); check("vrd_t1", 64'(ctl_now()), 64'd0);
    i_vram_data = 8'h5A;
    tick(); check("vrd_t2", 64'(ctl_now()), 64'd0);
    tick(); check("vrd_t3", 64'(ctl_now()), 64'(6'b000010));
    check("vrd_data", 64'(o_vid_data), 64'h5A);
    i_vram_data = 8'h00;

    for (int i = 0; i < 15; i++) begin
      i_vid_req = vec[i].vid_req; i_vid_addr = vec[i].vid_addr;
      i_cpu_req = vec[i].cpu_req; i_cpu_we = vec[i].cpu_we;
      i_cpu_addr = vec[i].cpu_addr; i_cpu_wdata = vec[i].cpu_wdata; i_vram_data = vec[i].vram;
      tick();
      check($sformatf("vec%0d_ctl", i),   64'(ctl_now()),    64'(vec[i].ctl));
      check($sformatf("vec%0d_addr", i),  64'(o_vram_addr),  64'(vec[i].addr));
      check($sformatf("vec%0d_wdat", i),  64'(o_vram_wdata), 64'(vec[i].wdat));
      check($sformatf("vec%0d_vdat", i),  64'(o_vid_data),   64'(vec[i].vdat));
      check($sformatf("vec%0d_cdat", i),  64'(o_cpu_rdata),  64'(vec[i].cdat));
    end

    // Both requesting reads continuously: expect V V V C repeating, one grant every 3 cycles.
    for (int i = 0; i < 16; i++) begin g_cyc[i] = -1; g_cpu[i] = 1'b0; end
    ng = 0; dual = 0;
    i_vid_req = 1'b1; i_vid_addr = 24'h000100;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 24'h000200; i_vram_data = 8'h33;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_vid_ack && o_cpu_ack) dual++;
      if (o_vid_ack || o_cpu_ack) begin
        if (ng < 16) begin g_cyc[ng] = c; g_cpu[ng] = o_cpu_ack; end
        ng++;
      end
      if (c == 40) begin i_vid_req = 1'b0; i_cpu_req = 1'b0; end
    end
    check("starve_ngrants", 64'(ng), 64'd14);
    check("starve_dual_ack", 64'(dual), 64'd0);
    for (int i = 0; i < 14; i++)
      check($sformatf("starve_grant%0d", i), {g_cyc[i], 31'b0, g_cpu[i]},
            {32'(1 + 3 * i), 31'b0, ((i % 4) == 3) ? 1'b1 : 1'b0});
    repeat (5) tick();

    // Reset asserted during the RDWAIT cycle of a CPU read.
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 24'h000555;
    tick(); check("mid_rd_grant", 64'(ctl_now()), 64'(6'b100100));
    i_cpu_req = 1'b0; i_vram_data = 8'hEE;
    tick();
    i_reset_n = 1'b0;
    #1 check("mid_rd_rst_outs", 64'(all_outs()), 64'd0);
    seen = 1'b0;
    tick(); seen |= o_cpu_valid;
    tick(); seen |= o_cpu_valid;
    i_reset_n = 1'b1;
    repeat (4) begin tick(); seen |= o_cpu_valid; end
    check("mid_rd_no_valid", 64'(seen), 64'd0);
    i_cpu_req = 1'b1; i_cpu_addr = 24'h000556;
    tick(); check("fresh_grant", 64'(ctl_now()), 64'(6'b100100));
    check("fresh_addr", 64'(o_vram_addr), 64'h000556);
    i_cpu_req = 1'b0;
    tick(); check("fresh_t1", 64'(ctl_now()), 64'd0);
    i_vram_data = 8'h77;
    tick(); check("fresh_t2", 64'(ctl_now()), 64'd0);
    tick(); check("fresh_valid", 64'(ctl_now()), 64'(6'b000001));
    check("fresh_data", 64'(o_cpu_rdata), 64'h77);

`ifdef VRAM_ARB_STATS_EN
    i_stat_clr = 1'b1; tick(); i_stat_clr = 1'b0;
    check("stat_pre_clr", 64'({o_stat_vid_cnt, o_stat_cpu_cnt, o_stat_starve_cnt}), 64'd0);
    i_vid_req = 1'b1; i_vid_addr = 24'h000300;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 24'h000301;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (o_cpu_ack) begin seen = 1'b1; i_vid_req = 1'b0; i_cpu_req = 1'b0; end
    end
    check("stat_cpu_ack_seen", 64'(seen), 64'd1);
    i_vid_req = 1'b0; i_cpu_req = 1'b0;
    repeat (4) tick();
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 24'h000302; i_cpu_wdata = 8'h01;
    tick(); i_cpu_req = 1'b0;
    tick();
    check("stat_counts", 64'({o_stat_vid_cnt, o_stat_cpu_cnt, o_stat_starve_cnt}),
          64'({16'd3, 16'd2, 16'd1}));
    i_stat_clr = 1'b1; tick(); i_stat_clr = 1'b0;
    check("stat_clr", 64'({o_stat_vid_cnt, o_stat_cpu_cnt, o_stat_starve_cnt}), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences and shares the single 8-bit VRAM port between two requesters: the VGA character/pixel fetch path and the CPU bus.
- Video fetch has fixed priority. A bounded-wait counter guarantees the CPU forward progress.
- Sits between the VGA controller's VRAM address/data bus and the external VRAM device. One access is in flight at a time.

Parameters:
- AW, 24, VRAM address width
- RD_LAT, 2, cycles from the CS cycle to valid i_vram_data (legal 1..7)
- MAX_WAIT, 8, CPU wait cycles after which the CPU beats video (legal 1..255)

Ports:
- i_clk  in  1  system clock; single clock domain
- i_reset_n  in  1  asynchronous, active-low reset
- i_vid_req  in  1  video read request; held with address until ack
- i_vid_addr  in  AW  video read address
- o_vid_ack  out  1  one-cycle grant pulse, in the same cycle as VRAM CS
- o_vid_valid  out  1  one-cycle read-data strobe
- o_vid_data  out  8  registered read data
- i_cpu_req  in  1  CPU request; held with we/addr/wdata until ack
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  AW  CPU address
- i_cpu_wdata  in  8  CPU write data
- o_cpu_ack  out  1  one-cycle grant pulse
- o_cpu_valid  out  1  one-cycle read-data strobe (reads only)
- o_cpu_rdata  out  8  registered read data
- o_vram_cs  out  1  VRAM access strobe
- o_vram_we  out  1  VRAM write enable, qualified by cs
- o_vram_addr  out  AW  VRAM address, registered
- o_vram_wdata  out  8  VRAM write data
- i_vram_data  in  8  VRAM read data

Behaviour:
- **Reset:** async assert drives all outputs to 0, state to IDLE, wait counter to 0, and pending-read owner to none. Deassertion is synchronised internally (2-flop).
- **Reset mid-read:** the in-flight read is discarded and no valid pulse is produced.
- **States:** IDLE, ACCESS, RDWAIT.
- **IDLE:** grant is evaluated every cycle. Outputs are registered, so a grant decided in cycle T-1 yields cs/ack in cycle T.
  - Grant is video if i_vid_req is high and (i_cpu_req is low or wait_cnt < MAX_WAIT). Otherwise grant is CPU if i_cpu_req is high.
  - Simultaneous requests with wait_cnt < MAX_WAIT: video wins.
- **ACCESS (one cycle, T):**
  - o_vram_cs=1. o_vram_we=1 only for a CPU write.
  - addr/wdata latched from the winner; the matching ack=1.
  - Write → IDLE; a new access may start at T+1 (back-to-back).
  - Read → RDWAIT.
- **RDWAIT:**
  - Counts RD_LAT-1 cycles, then samples i_vram_data at the end of cycle T+RD_LAT.
  - The owner's valid=1 and data appear in cycle T+RD_LAT+1.
  - The next CS occurs no earlier than T+RD_LAT+1.
  - RD_LAT=1 skips RDWAIT.
- **Data hold:** o_*_data holds its last value between valids. Unused data registers are not cleared.
- **wait_cnt (8 bit):**
  - Increments each cycle i_cpu_req=1 and the CPU is not acked.
  - Saturates at MAX_WAIT.
  - Clears on o_cpu_ack or when i_cpu_req=0.
- **Busy states:** requests arriving in ACCESS/RDWAIT wait. Video request lines are not latched before grant.
- **Protocol violation:** a requester dropping req before ack is legal (request withdrawn). Changing addr before ack is a requester error; the arbiter samples at grant only.
- **Stable outputs:** o_vram_addr/o_vram_wdata hold their last value when cs=0; o_vram_we=0 when cs=0.

Optional Feature:
- VRAM_ARB_STATS_EN
- **Defined:** adds outputs o_stat_vid_cnt[15:0], o_stat_cpu_cnt[15:0] (grants per requester, wrapping) and o_stat_starve_cnt[15:0] (CPU grants forced by wait_cnt==MAX_WAIT), plus input i_stat_clr (synchronous clear to 0, priority over increment). All reset to 0.
- **Undefined:** these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with i_vid_req=1 → all outputs 0; first o_vram_cs at least 1 cycle after synchronised deassert, with o_vid_ack in the same cycle.
- Video read of addr 0x000123, RD_LAT=2, VRAM returns 0x5A in cycle T+2 → o_vid_valid=1, o_vid_data=0x5A in cycle T+3; o_cpu_valid stays 0.
- CPU write 0xA5 to 0x00FFFF, two back-to-back writes → cs/we high in consecutive cycles T, T+1 with correct addr/wdata; o_cpu_ack each cycle; no o_cpu_valid.
- Both requesting continuously, MAX_WAIT=8 → video is granted repeatedly; once wait_cnt reaches 8, the next grant is CPU and the counter clears. Check the pattern repeats.
- Reset asserted in the RDWAIT cycle of a CPU read → no o_cpu_valid ever appears; the next access behaves as fresh.
- With VRAM_ARB_STATS_EN: 3 video + 2 CPU grants, including 1 starvation-forced → counts 3/2/1; assert i_stat_clr → all 0 the next cycle.
